sprite_attr_table: RTL and testbench

Parametrised, double-buffered sprite attribute register file on the Avalon-MM slave side of the VGA sprite path.
- CPU writes land in a shadow bank.
- The shadow bank is copied to the active bank only at a frame boundary, after the CPU requests a commit, so the sprite controller never displays a half-updated frame.
- The sprite controller reads the active bank through an indexed, registered lookup port.
- The CPU can read back the shadow bank and a status word.

---
 rtl/sprite_attr_table.sv | 72 +++++++
 tb/tb_sprite_attr_table.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sprite_attr_table.sv
// sprite_attr_table: double-buffered sprite attribute file, CPU writes shadow, frame-boundary commit to active bank.
module sprite_attr_table #(
  parameter int NUM_SPRITES = 20,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int CLEAR_ADDR = 60,
  parameter int COMMIT_ADDR = 61,
  parameter int STATUS_ADDR = 62,
  localparam int SEL_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chipselect,
  input  logic              write,
  input  logic              read,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  input  logic              frame_start,
  input  logic [SEL_W-1:0]  sprite_sel,
  output logic [DATA_W-1:0] sprite_attr,
  output logic              commit_pending,
  output logic [15:0]       frame_count
);
  if (CLEAR_ADDR < NUM_SPRITES || COMMIT_ADDR < NUM_SPRITES || STATUS_ADDR < NUM_SPRITES ||
      CLEAR_ADDR == COMMIT_ADDR || CLEAR_ADDR == STATUS_ADDR || COMMIT_ADDR == STATUS_ADDR) begin : g_bad_map
    $error("sprite_attr_table: control addresses overlap slots or each other");
  end
  localparam logic [ADDR_W-1:0] NS_A = ADDR_W'(NUM_SPRITES);
  localparam logic [ADDR_W-1:0] CLR_A = ADDR_W'(CLEAR_ADDR);
  localparam logic [ADDR_W-1:0] CMT_A = ADDR_W'(COMMIT_ADDR);
  localparam logic [ADDR_W-1:0] STS_A = ADDR_W'(STATUS_ADDR);
  logic [DATA_W-1:0] shadow [NUM_SPRITES];
  logic [DATA_W-1:0] active [NUM_SPRITES];
  logic wr, rd, commit, slot_hit, sel_ok;
  logic [SEL_W-1:0] a_idx;
  logic [31:0] status;
  always_comb begin
    wr = chipselect && write;
    rd = chipselect && read;
    commit = frame_start && commit_pending;
    slot_hit = address < NS_A;
    a_idx = address[SEL_W-1:0];
    sel_ok = {1'b0, sprite_sel} < (SEL_W+1)'(NUM_SPRITES);
    status = {frame_count, 15'b0, commit_pending};
  end
  // Lookup bypasses from shadow on a commit edge so the new bank is visible right after the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      readdata <= '0;
      sprite_attr <= '0;
      commit_pending <= 1'b0;
      frame_count <= '0;
    end else begin
      if (commit)
        for (int i = 0; i < NUM_SPRITES; i++) active[i] <= shadow[i];
      if (wr && address == CLR_A)
        for (int i = 0; i < NUM_SPRITES; i++) shadow[i] <= '0;
      else if (wr && slot_hit)
        shadow[a_idx] <= writedata;
      commit_pending <= (wr && address == CMT_A) ? 1'b1 : commit ? 1'b0 : commit_pending;
      frame_count <= frame_count + 16'(frame_start);
      if (rd)
        readdata <= slot_hit ? shadow[a_idx] : (address == STS_A) ? DATA_W'(status) : '0;
      sprite_attr <= !sel_ok ? '0 : commit ? shadow[sprite_sel] : active[sprite_sel];
    end
  end
endmodule

// File: tb/tb_sprite_attr_table.sv
// tb_sprite_attr_table: randomized bench against a bank-level reference model plus directed literal checks.
module tb_sprite_attr_table;
  logic clk = 0;
  logic reset = 1;
  logic chipselect = 0, write = 0, read = 0, frame_start = 0;
  logic [5:0] address = 0;
  logic [31:0] writedata = 0;
  logic [4:0] sprite_sel = 0;
  logic [31:0] readdata, sprite_attr;
  logic commit_pending;
  logic [15:0] frame_count;
  int n_chk = 0, n_fail = 0;
  logic chk_en = 0;
  logic [31:0] sh [20];
  logic [31:0] ac [20];
  logic [31:0] old_sh [20];
  logic pend = 0, old_pend;
  logic [15:0] fc = 0;
  logic [31:0] rd_m = 0, sa_m = 0;
  logic cmt;

  sprite_attr_table dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata), .frame_start(frame_start),
    .sprite_sel(sprite_sel), .sprite_attr(sprite_attr), .commit_pending(commit_pending),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 20; i++) begin sh[i] = 0; ac[i] = 0; end

  // Reference: banks as arrays, every rule applied to pre-edge values.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 20; i++) begin sh[i] = 0; ac[i] = 0; end
      pend = 0; fc = 0; rd_m = 0; sa_m = 0;
    end else begin
      old_sh = sh;
      old_pend = pend;
      cmt = frame_start && pend;
      if (cmt) ac = old_sh;
      if (chipselect && write) begin
        if (address < 20) sh[address] = writedata;
        else if (address == 60) for (int i = 0; i < 20; i++) sh[i] = 0;
      end
      if (cmt) pend = 0;
      if (chipselect && write && address == 61) pend = 1;
      if (chipselect && read)
        rd_m = (address < 20) ? old_sh[address] : (address == 62) ? {fc, 15'b0, old_pend} : 0;
      fc = fc + 16'(frame_start);
      sa_m = (sprite_sel < 20) ? ac[sprite_sel] : 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      chk("readdata", readdata, rd_m);
      chk("sprite_attr", sprite_attr, sa_m);
      chk("commit_pending", {31'b0, commit_pending}, {31'b0, pend});
      chk("frame_count", {16'b0, frame_count}, {16'b0, fc});
    end
  end

  task automatic step(input logic cs, input logic w, input logic r, input logic [5:0] a,
                      input logic [31:0] d, input logic fs, input logic [4:0] s);
    @(negedge clk);
    chipselect = cs; write = w; read = r; address = a; writedata = d; frame_start = fs; sprite_sel = s;
    @(posedge clk);
    #3;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic fs, input logic [4:0] s);
    step(1, 1, 0, a, d, fs, s);
  endtask

  task automatic rd(input logic [5:0] a, input logic [4:0] s);
    step(1, 0, 1, a, 0, 0, s);
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    logic [5:0] a;
    int r;
    repeat (2) @(negedge clk);
    reset = 0;
    chk_en = 1;
    chk("reset_sprite_attr", sprite_attr, 0);
    chk("reset_frame_count", {16'b0, frame_count}, 0);
    // 1: shadow write invisible to lookup, visible on readback
    wr(3, 32'hDEADBEEF, 0, 3);
    step(0, 0, 0, 0, 0, 0, 3);
    chk("t1_sprite_attr", sprite_attr, 0);
    rd(3, 3);
    chk("t1_readback", readdata, 32'hDEADBEEF);
    chk("t1_pending", {31'b0, commit_pending}, 0);
    // 2: commit on frame boundary
    wr(3, 32'h12345678, 0, 3);
    wr(61, 32'hFFFFFFFF, 0, 3);
    chk("t2_pending_armed", {31'b0, commit_pending}, 1);
    step(0, 0, 0, 0, 0, 1, 3);
    chk("t2_pending_clr", {31'b0, commit_pending}, 0);
    step(0, 0, 0, 0, 0, 0, 3);
    chk("t2_sprite_attr", sprite_attr, 32'h12345678);
    chk("t2_frame_count", {16'b0, frame_count}, 1);
    // 3: slot write coincident with commit edge
    wr(0, 32'h55, 0, 0);
    wr(61, 0, 0, 0);
    wr(0, 32'hAA, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("t3_active_old", sprite_attr, 32'h55);
    rd(0, 0);
    chk("t3_shadow_new", readdata, 32'hAA);
    wr(61, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("t3_active_new", sprite_attr, 32'hAA);
    // 4: fill, clear, commit; then stray writes
    for (int i = 0; i < 20; i++) wr(6'(i), $urandom | 1, 0, 0);
    wr(60, 32'hFFFFFFFF, 0, 0);
    chk("t4_clear_no_arm", {31'b0, commit_pending}, 0);
    wr(61, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 0, 0, 0, 5'(i));
      chk("t4_active_zero", sprite_attr, 0);
    end
    rd(62, 0);
    chk("t4_status_pending", {31'b0, readdata[0]}, 0);
    for (int i = 20; i < 60; i++) wr(6'(i), $urandom, 0, 0);
    wr(63, $urandom, 0, 0);
    wr(62, $urandom, 0, 0);
    chk("t4_stray_no_arm", {31'b0, commit_pending}, 0);
    for (int i = 0; i < 20; i++) begin
      rd(6'(i), 0);
      chk("t4_shadow_zero", readdata, 0);
    end
    // 5: async reset discards armed commit
    wr(3, 32'hCAFEF00D, 0, 3);
    wr(61, 0, 0, 3);
    @(negedge clk);
    chipselect = 0; write = 0; read = 0; frame_start = 0;
    #2 reset = 1;
    #1;
    chk("t5_async_pending", {31'b0, commit_pending}, 0);
    chk("t5_async_sprite", sprite_attr, 0);
    chk("t5_async_fc", {16'b0, frame_count}, 0);
    chk("t5_async_readdata", readdata, 0);
    @(negedge clk);
    reset = 0;
    step(0, 0, 0, 0, 0, 1, 3);
    step(0, 0, 0, 0, 0, 0, 3);
    chk("t5_no_commit", sprite_attr, 0);
    chk("t5_pending", {31'b0, commit_pending}, 0);
    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      r = $urandom_range(0, 31);
      a = (r < 18) ? 6'($urandom_range(0, 19)) : (r == 18) ? 6'd60 : (r < 23) ? 6'd61 :
          (r < 27) ? 6'd62 : 6'($urandom_range(0, 63));
      step($urandom_range(0, 7) != 0, $urandom_range(0, 1), $urandom_range(0, 1), a, $urandom,
           $urandom_range(0, 7) == 0, 5'($urandom_range(0, 22)));
    end
    // 6: frame counter wrap
    do_reset();
    for (int i = 0; i < 65535; i++) step(0, 0, 0, 0, 0, 1, 0);
    chk("t6_fc_max", {16'b0, frame_count}, 32'h0000FFFF);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("t6_fc_wrap", {16'b0, frame_count}, 0);
    rd(62, 0);
    chk("t6_status", readdata, 0);
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
